// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: expands one register read/write request into I2C master byte commands.
// Optional I2C_SEQ_TIMEOUT_EN aborts a command whose completion never arrives (e.g. NACK).
module i2c_txn_sequencer #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rw,
    input  logic [6:0]       req_dev,
    input  logic [7:0]       req_reg,
    input  logic [LEN_W-1:0] req_len,
    input  logic [7:0]       wdata,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    output logic [7:0]       rdata,
    output logic             rdata_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             m_i2c_en,
    output logic             m_start,
    output logic             m_stop,
    output logic [7:0]       m_tx_data,
    input  logic             m_ready,
    input  logic [7:0]       m_rx_data
);
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR_W, S_REG, S_WDATA,
        S_STOP_P, S_RESTART, S_ADDR_R, S_RDATA, S_STOP
    } state_t;

    state_t           r_state, w_state_nx, w_next;
    logic             r_wait, w_wait_nx;
    logic             r_prev_rdy, r_rw, r_loaded, r_done, r_rdata_valid;
    logic [6:0]       r_dev;
    logic [7:0]       r_reg, r_wbyte, r_rdata;
    logic [LEN_W-1:0] r_cnt;
    logic             w_issue, w_rise, w_accept, w_fin, w_tmo, w_byte_done;

    if (LEN_W < 1 || TIMEOUT < 2) begin : g_cfg_check
        $error("i2c_txn_sequencer: LEN_W must be >= 1 and TIMEOUT >= 2");
    end

    assign busy        = r_state != S_IDLE;
    assign req_ready   = r_state == S_IDLE && m_ready;
    assign w_accept    = req_valid && req_ready;
    assign w_issue     = busy && !r_wait;
    assign w_rise      = m_ready && !r_prev_rdy;
    assign w_byte_done = r_wait && w_rise;
    assign wdata_ready = r_state == S_WDATA && w_issue && !r_loaded && wdata_valid;
    // A data byte is only offered to the master once it has been loaded.
    assign m_i2c_en    = w_issue && (r_state != S_WDATA || r_loaded);
    assign m_start     = w_issue && r_state inside {S_START, S_RESTART, S_RDATA};
    assign m_stop      = w_issue && r_state inside {S_STOP_P, S_STOP, S_RDATA};
    assign m_tx_data   = r_state == S_ADDR_W ? {r_dev, 1'b0} :
                         r_state == S_ADDR_R ? {r_dev, 1'b1} :
                         r_state == S_REG    ? r_reg :
                         r_state == S_WDATA  ? r_wbyte : 8'h00;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign done        = r_done;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] r_tmo;
    logic          r_err;
    assign w_tmo = r_wait && !w_rise && r_tmo == TW'(TIMEOUT - 1);
    assign err   = r_err;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_tmo <= (r_wait && !w_rise && !w_tmo) ? r_tmo + 1'b1 : '0;
            r_err <= w_tmo;
        end
    end
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

    // State that follows the current command once it completes.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_START:          w_next = S_ADDR_W;
            S_ADDR_W:         w_next = S_REG;
            S_REG:            w_next = r_rw ? S_STOP_P : (r_cnt == '0 ? S_STOP : S_WDATA);
            S_WDATA, S_RDATA: w_next = r_cnt == LEN_W'(1) ? S_STOP : r_state;
            S_STOP_P:         w_next = r_cnt == '0 ? S_IDLE : S_RESTART;
            S_RESTART:        w_next = S_ADDR_R;
            S_ADDR_R:         w_next = S_RDATA;
            default:          w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_wait_nx  = r_wait;
        w_fin      = 1'b0;
        if (r_state == S_IDLE) begin
            w_state_nx = w_accept ? S_START : S_IDLE;
        end else if (!r_wait) begin
            w_wait_nx = m_i2c_en && !m_ready;
        end else if (w_rise) begin
            w_wait_nx  = 1'b0;
            w_state_nx = w_next;
            w_fin      = w_next == S_IDLE;
        end else if (w_tmo) begin
            w_wait_nx  = 1'b0;
            w_state_nx = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_wait  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_wait  <= w_wait_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev_rdy    <= 1'b0;
            r_rw          <= 1'b0;
            r_dev         <= '0;
            r_reg         <= '0;
            r_cnt         <= '0;
            r_loaded      <= 1'b0;
            r_wbyte       <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_prev_rdy    <= m_ready;
            r_done        <= w_fin;
            r_rdata_valid <= w_byte_done && r_state == S_RDATA;
            if (w_accept) begin
                r_rw     <= req_rw;
                r_dev    <= req_dev;
                r_reg    <= req_reg;
                r_cnt    <= req_len;
                r_loaded <= 1'b0;
            end
            if (wdata_ready) begin
                r_wbyte  <= wdata;
                r_loaded <= 1'b1;
            end
            if (w_byte_done && (r_state == S_WDATA || r_state == S_RDATA)) begin
                r_cnt    <= r_cnt - 1'b1;
                r_loaded <= 1'b0;
            end
            if (w_byte_done && r_state == S_RDATA)
                r_rdata <= m_rx_data;
        end
    end
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: random and directed requests against a byte-level master model;
// the expected bus token list is built from the request alone.
module tb_i2c_txn_sequencer;
    localparam int LEN_W = 4;
    localparam int T_S = 256, T_P = 512, T_R = 768;

    logic clk = 1'b0, reset = 1'b0;
    logic req_valid = 1'b0, req_rw = 1'b0;
    logic [6:0] req_dev = '0;
    logic [7:0] req_reg = '0;
    logic [LEN_W-1:0] req_len = '0;
    logic [7:0] wdata = '0;
    logic wdata_valid = 1'b0;
    logic req_ready, wdata_ready, rdata_valid, busy, done, err, m_i2c_en, m_start, m_stop;
    logic [7:0] rdata, m_tx_data;
    logic m_ready = 1'b1;
    logic [7:0] m_rx_data = '0;

    int n_cmp = 0, n_bad = 0;
    int bus_q[$];
    logic [7:0] slave_q[$], wq[$], got_rd[$];
    int lat = 0, ncyc = 0, t_stuck = 0, t_err = 0;
    bit stuck = 0, nack_arm = 0, take = 0, gapping = 0;
    int gap_idx = -1, gap_left = 0, wcons = 0, gap_en = 0;
    int done_cnt = 0, err_cnt = 0, wr_cnt = 0, done_busy = 0, rr_viol = 0;

    i2c_txn_sequencer #(.LEN_W(LEN_W), .TIMEOUT(4096)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_dev(req_dev), .req_reg(req_reg), .req_len(req_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done), .err(err),
        .m_i2c_en(m_i2c_en), .m_start(m_start), .m_stop(m_stop), .m_tx_data(m_tx_data),
        .m_ready(m_ready), .m_rx_data(m_rx_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte-level master, output monitor and write-data feeder, all away from the active edge.
    always @(negedge clk) begin
        ncyc++;
        if (take) begin
            void'(wq.pop_front());
            wcons++;
        end
        if (!reset) begin
            m_ready = 1'b1;
            stuck = 0;
        end else if (!m_ready) begin
            if (lat > 1) lat--;
            else if (!stuck) m_ready = 1'b1;
        end else if (m_i2c_en) begin
            m_ready = 1'b0;
            lat = $urandom_range(1, 4);
            case ({m_start, m_stop})
                2'b10: bus_q.push_back(T_S);
                2'b01: bus_q.push_back(T_P);
                2'b11: begin
                    bus_q.push_back(T_R);
                    m_rx_data = slave_q.size() > 0 ? slave_q.pop_front() : 8'h00;
                end
                default: begin
                    bus_q.push_back(int'(m_tx_data));
                    if (nack_arm) begin
                        stuck = 1;
                        nack_arm = 0;
                        t_stuck = ncyc;
                    end
                end
            endcase
        end
        if (rdata_valid) got_rd.push_back(rdata);
        if (done) begin
            done_cnt++;
            if (busy) done_busy++;
        end
        if (err) begin
            err_cnt++;
            t_err = ncyc;
        end
        if (busy && req_ready) rr_viol++;
        gapping = wcons == gap_idx && gap_left > 0;
        if (gapping) gap_left--;
        if (gapping && gap_left < 4900 && m_i2c_en) gap_en++;
        wdata_valid = wq.size() > 0 && !gapping;
        wdata = wq.size() > 0 ? wq[0] : 8'h00;
        #1;
        take = reset && wdata_valid && wdata_ready;
        if (take) wr_cnt++;
    end

    task automatic send(input bit rw, input logic [6:0] dev, input logic [7:0] rg, input int len);
        int t = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_rw = rw;
        req_dev = dev;
        req_reg = rg;
        req_len = LEN_W'(len);
        @(negedge clk);
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("req_ready", int'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("start_levels", int'({m_i2c_en, m_start, m_stop}), 3'b110);
    endtask

    task automatic run(input bit rw, input logic [6:0] dev, input logic [7:0] rg, input int len, input int gidx);
        int exp_bus[$];
        logic [7:0] exp_rd[$];
        int t = 0;
        bus_q.delete();
        got_rd.delete();
        done_cnt = 0; err_cnt = 0; wr_cnt = 0; done_busy = 0; wcons = 0; gap_en = 0;
        gap_idx = gidx;
        gap_left = gidx >= 0 ? 5000 : 0;
        if (!rw) while (wq.size() < len) wq.push_back(8'($urandom));
        else while (slave_q.size() < len) slave_q.push_back(8'($urandom));
        exp_bus.push_back(T_S);
        exp_bus.push_back(int'({dev, 1'b0}));
        exp_bus.push_back(int'(rg));
        if (rw) begin
            exp_bus.push_back(T_P);
            if (len > 0) begin
                exp_bus.push_back(T_S);
                exp_bus.push_back(int'({dev, 1'b1}));
                for (int i = 0; i < len; i++) exp_bus.push_back(T_R);
                exp_bus.push_back(T_P);
                exp_rd = slave_q;
            end
        end else begin
            foreach (wq[i]) exp_bus.push_back(int'(wq[i]));
            exp_bus.push_back(T_P);
        end
        send(rw, dev, rg, len);
        // A request offered while busy must be ignored.
        #20;
        req_valid = 1'b1;
        req_dev = ~dev;
        req_reg = ~rg;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        while (done_cnt == 0 && err_cnt == 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("done_count", done_cnt, 1);
        check("err_count", err_cnt, 0);
        check("done_with_busy", done_busy, 0);
        check("busy_after", int'(busy), 0);
        check("wdata_pulses", wr_cnt, rw ? 0 : len);
        check("req_ready_while_busy", rr_viol, 0);
        check("bus_len", bus_q.size(), exp_bus.size());
        foreach (exp_bus[i]) check($sformatf("bus[%0d]", i), i < bus_q.size() ? bus_q[i] : -1, exp_bus[i]);
        check("rdata_len", got_rd.size(), exp_rd.size());
        foreach (exp_rd[i]) check($sformatf("rdata[%0d]", i), i < got_rd.size() ? int'(got_rd[i]) : -1, int'(exp_rd[i]));
        if (gidx >= 0) check("en_during_gap", gap_en, 0);
        wq.delete();
        slave_q.delete();
        gap_idx = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_cmd"}, int'({m_i2c_en, m_start, m_stop}), 0);
        check({tag, "_tx"}, int'(m_tx_data), 0);
        check({tag, "_rdata"}, int'(rdata), 0);
        check({tag, "_pulses"}, int'({done, err, rdata_valid, wdata_ready}), 0);
        check({tag, "_req_ready"}, int'(req_ready), int'(m_ready));
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #2 reset = 1'b1;

        wq = '{8'hA5, 8'h3C};
        run(1'b0, 7'h50, 8'h10, 2, -1);
        slave_q = '{8'h11, 8'h22, 8'h33};
        run(1'b1, 7'h50, 8'h20, 3, -1);
        run(1'b0, 7'h50, 8'h10, 0, -1);
        run(1'b1, 7'h2C, 8'h01, 0, -1);
        wq = '{8'h5A, 8'hC3};
        run(1'b0, 7'h3A, 8'h07, 2, 1);
        run(1'b0, 7'h7F, 8'hFF, 15, -1);
        run(1'b1, 7'h00, 8'h00, 15, -1);

        // Asynchronous reset in the middle of the second data byte.
        wq = '{8'h66, 8'h99};
        wr_cnt = 0;
        send(1'b0, 7'h22, 8'h44, 2);
        t = 0;
        while (wr_cnt < 2 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("reached_byte2", wr_cnt, 2);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        wq.delete();
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("req_ready_after_reset", int'(req_ready), 1);
        run(1'b0, 7'h22, 8'h44, 3, -1);

        for (int k = 0; k < 10; k++)
            run(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), $urandom_range(0, 15), -1);

`ifdef I2C_SEQ_TIMEOUT_EN
        wq = '{8'h99};
        nack_arm = 1;
        err_cnt = 0;
        done_cnt = 0;
        send(1'b0, 7'h50, 8'h10, 1);
        t = 0;
        while (err_cnt == 0 && t < 6000) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        check("timeout_err", err_cnt, 1);
        check("timeout_delay", t_err - t_stuck, 4097);
        check("timeout_done", done_cnt, 0);
        check("timeout_busy", int'(busy), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        wq.delete();
        @(posedge clk);
        #2 reset = 1'b1;
        run(1'b0, 7'h50, 8'h10, 1, -1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
